// File: rtl/shift_engine.sv
`timescale 1ns/1ps
`default_nettype none
// shift_engine: multi-cycle shifter/rotator moving at most STEP bit positions per clock.
// Results, carry, zero and error flags are registered and updated only at completion.
module shift_engine #(
  parameter int DATA_WIDTH  = 16,
  parameter int STEP        = 4,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [DATA_WIDTH-1:0]  A,
  input  logic [DATA_WIDTH-1:0]  B,
  input  logic                   SRC_SEL,
  input  logic [2:0]             MODE,
  input  logic [SHAMT_WIDTH-1:0] SHAMT,
  input  logic                   Shift_Enable,
  output logic                   Busy,
  output logic [DATA_WIDTH-1:0]  Shift_OUT,
  output logic                   Shift_Flag,
  output logic                   Carry_OUT,
  output logic                   Zero_OUT,
  output logic                   Err_OUT
);

  localparam logic [2:0] MODE_LSR = 3'b000;
  localparam logic [2:0] MODE_LSL = 3'b001;
  localparam logic [2:0] MODE_ASR = 3'b010;
  localparam logic [2:0] MODE_ROR = 3'b011;
  localparam logic [2:0] MODE_ROL = 3'b100;

  localparam logic [SHAMT_WIDTH:0]   STEP_W     = STEP[SHAMT_WIDTH:0];
  localparam logic [SHAMT_WIDTH:0]   DW_W       = DATA_WIDTH[SHAMT_WIDTH:0];
  localparam logic [SHAMT_WIDTH-1:0] STEP_N_MAX = STEP_W[SHAMT_WIDTH-1:0];
  localparam logic [SHAMT_WIDTH-1:0] N_ONE      = {{(SHAMT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0]  LSB_ONE    = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0]  MSB_ONE    = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic [DATA_WIDTH-1:0]  work;
  logic [2:0]             op_mode;
  logic [SHAMT_WIDTH-1:0] remaining;
  logic                   carry_work;

  logic                   start;
  logic                   done;
  logic                   invalid;
  logic                   last_step;
  logic [SHAMT_WIDTH-1:0] step_n;
  logic [SHAMT_WIDTH:0]   inv_n;
  logic [DATA_WIDTH-1:0]  mask_right;
  logic [DATA_WIDTH-1:0]  mask_left;
  logic                   carry_right;
  logic                   carry_left;
  logic [DATA_WIDTH-1:0]  stepped;
  logic                   step_carry;

  assign Busy      = (state == SHIFT);
  assign invalid   = (op_mode > MODE_ROL);
  assign last_step = ({1'b0, remaining} <= STEP_W) || invalid;

  always_comb begin
    step_n      = remaining;
    if ({1'b0, remaining} > STEP_W) begin
      step_n = STEP_N_MAX;
    end
    inv_n       = DW_W - {1'b0, step_n};
    // The bit leaving the word last in this step sits at n-1 (right) or DW-n (left).
    mask_right  = LSB_ONE << (step_n - N_ONE);
    mask_left   = MSB_ONE >> (step_n - N_ONE);
    carry_right = |(work & mask_right);
    carry_left  = |(work & mask_left);
  end

  always_comb begin
    stepped    = '0;
    step_carry = carry_work;
    case (op_mode)
      MODE_LSR: begin
        stepped = work >> step_n;
        if (step_n != '0) step_carry = carry_right;
      end
      MODE_LSL: begin
        stepped = work << step_n;
        if (step_n != '0) step_carry = carry_left;
      end
      MODE_ASR: begin
        stepped = $unsigned($signed(work) >>> step_n);
        if (step_n != '0) step_carry = carry_right;
      end
      MODE_ROR: begin
        stepped = (work >> step_n) | (work << inv_n);
        if (step_n != '0) step_carry = carry_right;
      end
      MODE_ROL: begin
        stepped = (work << step_n) | (work >> inv_n);
        if (step_n != '0) step_carry = carry_left;
      end
      default: begin
        stepped    = '0;
        step_carry = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_next = state;
    start      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (Shift_Enable) begin
          start      = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (last_step) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      work       <= '0;
      op_mode    <= '0;
      remaining  <= '0;
      carry_work <= 1'b0;
      Shift_OUT  <= '0;
      Shift_Flag <= 1'b0;
      Carry_OUT  <= 1'b0;
      Zero_OUT   <= 1'b0;
      Err_OUT    <= 1'b0;
    end else begin
      Shift_Flag <= done;
      if (start) begin
        work       <= SRC_SEL ? B : A;
        op_mode    <= MODE;
        remaining  <= SHAMT;
        carry_work <= 1'b0;
      end else if (state == SHIFT) begin
        work       <= stepped;
        remaining  <= remaining - step_n;
        carry_work <= step_carry;
      end
      if (done) begin
        Shift_OUT <= invalid ? '0 : stepped;
        Carry_OUT <= invalid ? 1'b0 : step_carry;
        Zero_OUT  <= invalid ? 1'b1 : (stepped == '0);
        Err_OUT   <= invalid;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_engine.sv
`timescale 1ns/1ps
`default_nettype none
// Scoreboard bench for shift_engine: driver pushes model predictions, monitor checks on Shift_Flag.
module tb_shift_engine;

  localparam int DW   = 16;
  localparam int STEP = 4;
  localparam int SW   = 4;

  logic          CLK = 1'b0;
  logic          RST;
  logic [DW-1:0] A, B;
  logic          SRC_SEL;
  logic [2:0]    MODE;
  logic [SW-1:0] SHAMT;
  logic          Shift_Enable;
  logic          Busy;
  logic [DW-1:0] Shift_OUT;
  logic          Shift_Flag, Carry_OUT, Zero_OUT, Err_OUT;

  shift_engine #(.DATA_WIDTH(DW), .STEP(STEP), .SHAMT_WIDTH(SW)) dut (
    .CLK(CLK), .RST(RST), .A(A), .B(B), .SRC_SEL(SRC_SEL), .MODE(MODE),
    .SHAMT(SHAMT), .Shift_Enable(Shift_Enable), .Busy(Busy),
    .Shift_OUT(Shift_OUT), .Shift_Flag(Shift_Flag), .Carry_OUT(Carry_OUT),
    .Zero_OUT(Zero_OUT), .Err_OUT(Err_OUT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [DW-1:0] res;
    logic          carry;
    logic          zero;
    logic          err;
    int unsigned   done_cyc;
  } exp_t;

  exp_t        sbq[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic        rst_seen = 1'b0;
  exp_t        mon_e;
  logic [DW-1:0] last_res = '0;
  logic        last_c = 1'b0, last_z = 1'b0, last_e = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: each result bit is picked directly from the source operand.
  function automatic exp_t model(input logic src, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 input logic [2:0] mode, input int s);
    exp_t e;
    logic [DW-1:0] op;
    op = src ? b : a;
    e.res = '0; e.carry = 1'b0; e.err = 1'b0; e.done_cyc = 0;
    case (mode)
      3'd0: begin
        for (int i = 0; i < DW; i++) e.res[i] = (i + s < DW) ? op[i + s] : 1'b0;
        if (s > 0) e.carry = op[s - 1];
      end
      3'd1: begin
        for (int i = 0; i < DW; i++) e.res[i] = (i >= s) ? op[i - s] : 1'b0;
        if (s > 0) e.carry = op[DW - s];
      end
      3'd2: begin
        for (int i = 0; i < DW; i++) e.res[i] = (i + s < DW) ? op[i + s] : op[DW - 1];
        if (s > 0) e.carry = op[s - 1];
      end
      3'd3: begin
        for (int i = 0; i < DW; i++) e.res[i] = op[(i + s) % DW];
        if (s > 0) e.carry = op[s - 1];
      end
      3'd4: begin
        for (int i = 0; i < DW; i++) e.res[i] = op[(i - s + DW) % DW];
        if (s > 0) e.carry = op[DW - s];
      end
      default: e.err = 1'b1;
    endcase
    e.zero = (e.res == '0);
    return e;
  endfunction

  function automatic int latency(input logic [2:0] mode, input int s);
    if (mode > 3'd4 || s == 0) return 1;
    return (s + STEP - 1) / STEP;
  endfunction

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    rst_seen <= RST;
    if (!RST) sbq.delete();
  end

  always @(negedge CLK) begin
    if (!rst_seen) begin
      check("reset_out", 32'({Busy, Shift_OUT, Shift_Flag, Carry_OUT, Zero_OUT, Err_OUT}), 32'd0);
      last_res = '0; last_c = 1'b0; last_z = 1'b0; last_e = 1'b0;
    end else if (Shift_Flag) begin
      if (sbq.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_flag: got Shift_Flag=1 expected 0 (cycle %0d)", cyc);
      end else begin
        mon_e = sbq.pop_front();
        check("result",  32'(Shift_OUT), 32'(mon_e.res));
        check("carry",   32'(Carry_OUT), 32'(mon_e.carry));
        check("zero",    32'(Zero_OUT),  32'(mon_e.zero));
        check("err",     32'(Err_OUT),   32'(mon_e.err));
        check("latency", 32'(cyc),       32'(mon_e.done_cyc));
      end
      last_res = Shift_OUT; last_c = Carry_OUT; last_z = Zero_OUT; last_e = Err_OUT;
    end else begin
      check("hold", 32'({Shift_OUT, Carry_OUT, Zero_OUT, Err_OUT}),
            32'({last_res, last_c, last_z, last_e}));
    end
  end

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic start_op(input logic src, input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input logic [2:0] mode, input int s);
    exp_t e;
    int g = 0;
    while (Busy && g < 100) begin
      @(negedge CLK);
      g++;
    end
    if (Busy) begin
      n_checks++; n_fail++;
      $display("FAIL start_timeout: got Busy=1 expected 0 (cycle %0d)", cyc);
      return;
    end
    SRC_SEL = src; A = a; B = b; MODE = mode; SHAMT = SW'(s); Shift_Enable = 1'b1;
    e = model(src, a, b, mode, s);
    e.done_cyc = cyc + 1 + 32'(latency(mode, s));
    sbq.push_back(e);
    @(negedge CLK);
    Shift_Enable = 1'b0;
    A = DW'($urandom); B = DW'($urandom); MODE = 3'($urandom); SHAMT = SW'($urandom);
    SRC_SEL = 1'($urandom);
    check("busy_after_start", 32'(Busy), 32'd1);
  endtask

  // Start requests while busy, held through the completion edge, must all be dropped.
  task automatic hold_garbage();
    int g = 0;
    while (Busy && g < 50) begin
      A = DW'($urandom); B = DW'($urandom); MODE = 3'($urandom); SHAMT = SW'($urandom);
      SRC_SEL = 1'($urandom); Shift_Enable = 1'b1;
      @(negedge CLK);
      g++;
    end
    Shift_Enable = 1'b0;
  endtask

  initial begin
    int cnt;
    int g;
    RST = 1'b0; A = '0; B = '0; SRC_SEL = 1'b0; MODE = '0; SHAMT = '0; Shift_Enable = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);

    start_op(1'b0, 16'h8001, 16'h0000, 3'b001, 1);
    start_op(1'b0, 16'h8000, 16'h0000, 3'b010, 15);
    cnt = 1;
    while (Busy && cnt < 20) begin
      @(negedge CLK);
      if (Busy) cnt++;
    end
    check("asr15_busy_cycles", 32'(cnt), 32'd4);
    start_op(1'b1, 16'hFFFF, 16'h1234, 3'b100, 4);
    start_op(1'b1, 16'hFFFF, 16'h1234, 3'b011, 4);
    start_op(1'b1, 16'hFFFF, 16'h0000, 3'b000, 0);
    start_op(1'b0, 16'hBEEF, 16'h0000, 3'b111, 5);

    start_op(1'b0, 16'hF0F0, 16'h0000, 3'b000, 12);
    A = 16'h0FFF; MODE = 3'b001; SHAMT = 4'd3; Shift_Enable = 1'b1;
    @(negedge CLK);
    Shift_Enable = 1'b0;
    start_op(1'b0, 16'h1357, 16'h0000, 3'b000, 4);

    start_op(1'b0, 16'hAAAA, 16'h0000, 3'b000, 12);
    @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    start_op(1'b0, 16'h00F1, 16'h0000, 3'b011, 9);

    repeat (80) begin
      start_op(1'($urandom), DW'($urandom), DW'($urandom), 3'($urandom_range(0, 7)),
               int'($urandom_range(0, DW - 1)));
      if ($urandom_range(0, 1) == 1) hold_garbage();
    end

    g = 0;
    while (sbq.size() > 0 && g < 200) begin
      @(negedge CLK);
      g++;
    end
    check("drain_pending", 32'(sbq.size()), 32'd0);
    repeat (2) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_engine.md
SHIFT_ENGINE -- requirements
Module: shift_engine

Interface
REQ-001 Parameter DATA_WIDTH, default 16, operand/result width; power of two, >= 4.
REQ-002 Parameter STEP, default 4, max bit positions shifted per cycle; power of two, 1..DATA_WIDTH.
REQ-003 Parameter SHAMT_WIDTH, default $clog2(DATA_WIDTH), shift-amount width.
REQ-004 CLK  input  1  clock; all state updates on rising edge.
REQ-005 RST  input  1  synchronous active-low reset, sampled on rising CLK edge.
REQ-006 A  input  DATA_WIDTH  operand 0.
REQ-007 B  input  DATA_WIDTH  operand 1.
REQ-008 SRC_SEL  input  1  0 = shift A, 1 = shift B.
REQ-009 MODE  input  3  000 LSR, 001 LSL, 010 ASR, 011 ROR, 100 ROL, 101-111 invalid.
REQ-010 SHAMT  input  SHAMT_WIDTH  shift amount, 0..DATA_WIDTH-1.
REQ-011 Shift_Enable  input  1  start request; single-cycle or held.
REQ-012 Busy  output  1  operation in progress; high blocks new starts.
REQ-013 Shift_OUT  output  DATA_WIDTH  registered result.
REQ-014 Shift_Flag  output  1  one-cycle completion pulse, aligned with Shift_OUT update.
REQ-015 Carry_OUT  output  1  last bit shifted (or rotated) out.
REQ-016 Zero_OUT  output  1  1 when completed Shift_OUT == 0.
REQ-017 Err_OUT  output  1  1 when completed operation had invalid MODE.

Function
REQ-018 FSM states: IDLE, SHIFT; Busy = (state == SHIFT).
REQ-019 IDLE + Shift_Enable=1 at edge E0: capture selected operand, MODE, SHAMT into working regs; remaining <= SHAMT; go to SHIFT.
REQ-020 In SHIFT each edge shifts working reg by n = min(STEP, remaining); remaining -= n.
REQ-021 Completion edge = E0 + max(1, ceil(SHAMT/STEP)); at it: Shift_OUT, Carry_OUT, Zero_OUT, Err_OUT update, Shift_Flag <= 1, state -> IDLE.
REQ-022 Shift_Flag 0 on every edge other than a completion edge.
REQ-023 Shift_OUT/Carry_OUT/Zero_OUT/Err_OUT hold between completions.
REQ-024 Shift_Enable while Busy (incl. completion cycle) ignored; no queuing; inputs other than at E0 ignored.
REQ-025 LSR/LSL zero-fill; ASR fills with captured MSB; ROR/ROL wrap bits, no loss.
REQ-026 Carry_OUT: LSR/ASR/ROR = bit at position SHAMT-1 of captured operand; LSL/ROL = bit at DATA_WIDTH-SHAMT; SHAMT=0 -> 0.
REQ-027 SHAMT=0: one SHIFT cycle, Shift_OUT = captured operand, Carry_OUT = 0.
REQ-028 Invalid MODE: completes at E0+1, Shift_OUT = 0, Zero_OUT = 1, Carry_OUT = 0, Err_OUT = 1; valid modes give Err_OUT = 0.
REQ-029 Back-to-back: new start accepted earliest at edge after completion edge.

Reset
REQ-030 RST=0 at edge: state IDLE, Busy 0, Shift_OUT 0, Shift_Flag 0, Carry_OUT 0, Zero_OUT 0, Err_OUT 0, working regs 0.
REQ-031 Reset mid-operation aborts; no Shift_Flag pulse for aborted op; start accepted at first edge with RST=1.

Verification (DATA_WIDTH=16, STEP=4)
REQ-032 SRC_SEL=0, A=0x8001, LSL, SHAMT=1 -> E0+1: Shift_OUT=0x0002, Carry_OUT=1, Shift_Flag=1 one cycle.
REQ-033 A=0x8000, ASR, SHAMT=15 -> Busy 4 cycles, E0+4: Shift_OUT=0xFFFF, Carry_OUT=0.
REQ-034 SRC_SEL=1, B=0x1234, ROL, SHAMT=4 -> E0+1: Shift_OUT=0x2341, Carry_OUT=1; ROR SHAMT=4 -> 0x4123, Carry_OUT=0.
REQ-035 B=0x0000, LSR, SHAMT=0 -> E0+1: Shift_OUT=0x0000, Zero_OUT=1; MODE=111 -> Err_OUT=1, Shift_OUT=0.
REQ-036 Start LSR SHAMT=12, second start at E0+1 with different A -> ignored, only first result at E0+3; second start at E0+4 accepted.
REQ-037 RST=0 at E0+2 of SHAMT=12 op -> all outputs 0, no Shift_Flag; new op after release completes normally.
